// File: rtl/storage_bist_pkg.sv
// Shared types and status codes for the storage SRAM March C- self-test engine.
package storage_bist_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_M0_W,
        ST_M1_RD,
        ST_M1_CW,
        ST_M2_RD,
        ST_M2_CW,
        ST_M3_RD,
        ST_M3_CMP,
        ST_BLK_END,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        ELEM_M0,
        ELEM_M1,
        ELEM_M2,
        ELEM_M3
    } march_elem_t;

    localparam logic [7:0] CODE_STARTED = 8'hA0;
    localparam logic [7:0] CODE_DONE    = 8'hAB;

    // One-hot-ish block tag shown in the low byte of checkbits.
    function automatic logic [7:0] code(input logic [2:0] b);
        return 8'h40 >> b;
    endfunction

    function automatic march_elem_t elem_of(input state_t s);
        case (s)
            ST_M1_RD, ST_M1_CW:  return ELEM_M1;
            ST_M2_RD, ST_M2_CW:  return ELEM_M2;
            ST_M3_RD, ST_M3_CMP: return ELEM_M3;
            default:             return ELEM_M0;
        endcase
    endfunction

endpackage

// File: rtl/storage_bist_addr_gen.sv
// Word address counter for one march element: load, step up/down, last-address flag.
module storage_bist_addr_gen #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          step,
    input  logic          dir_down,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = load_val;
        end else if (step) begin
            addr_d = dir_down ? addr_q - 1'b1 : addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;
    // The element is reloaded at its last address, so the counter never wraps.
    assign last = dir_down ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/storage_bist.sv
// March C- BIST over NBLOCKS SRAM blocks with checkbits progress codes.
// Optional macro STORAGE_BIST_CONTINUE_EN: keep testing after a miscompare, add err_count/fail_mask.
module storage_bist
    import storage_bist_pkg::*;
#(
    parameter int          NBLOCKS = 2,
    parameter int          AW      = 8,
    parameter int          DW      = 32,
    parameter logic [31:0] BG      = 32'h5555_AAAA
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [2:0]            fail_block,
    output logic [AW-1:0]         fail_addr,
    output logic [15:0]           checkbits,
    output logic [NBLOCKS-1:0]    mem_csb,
    output logic                  mem_web,
    output logic [DW/8-1:0]       mem_wmask,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_din,
    input  logic [NBLOCKS*DW-1:0] mem_dout
`ifdef STORAGE_BIST_CONTINUE_EN
    ,
    output logic [15:0]           err_count,
    output logic [NBLOCKS-1:0]    fail_mask
`endif
);

    localparam logic [DW-1:0] P0       = DW'(BG);
    localparam logic [DW-1:0] P1       = ~P0;
    localparam logic [2:0]    BLK_LAST = 3'(NBLOCKS - 1);

    state_t          state_q, state_d;
    logic [2:0]      blk_q, blk_d;
    logic            fail_q, fail_d;
    logic [2:0]      fail_block_q, fail_block_d;
    logic [AW-1:0]   fail_addr_q, fail_addr_d;
    logic [15:0]     checkbits_q, checkbits_d;
`ifdef STORAGE_BIST_CONTINUE_EN
    logic            blk_err_q, blk_err_d;
    logic [15:0]     err_count_q, err_count_d;
    logic [NBLOCKS-1:0] fail_mask_q, fail_mask_d;
`endif

    logic            ag_load, ag_step, ag_last;
    logic [AW-1:0]   ag_load_val, ag_addr;
    logic [DW-1:0]   rd_data;
    logic [DW-1:0]   expected;
    logic [NBLOCKS-1:0] blk_onehot;
    logic            compare_cycle, miscompare, mem_access;

    storage_bist_addr_gen #(.AW(AW)) u_addr_gen (
        .clk      (wb_clk_i),
        .srst     (wb_rst_i),
        .load     (ag_load),
        .load_val (ag_load_val),
        .step     (ag_step),
        .dir_down (elem_of(state_q) == ELEM_M2),
        .addr     (ag_addr),
        .last     (ag_last)
    );

    always_comb begin
        rd_data    = '0;
        blk_onehot = '0;
        for (int i = 0; i < NBLOCKS; i++) begin
            if (blk_q == 3'(i)) begin
                rd_data       = mem_dout[i*DW +: DW];
                blk_onehot[i] = 1'b1;
            end
        end
    end

    assign expected      = (elem_of(state_q) == ELEM_M2) ? P1 : P0;
    assign compare_cycle = (state_q == ST_M1_CW) || (state_q == ST_M2_CW) || (state_q == ST_M3_CMP);
    assign miscompare    = compare_cycle && (rd_data != expected);

    always_comb begin
        state_d      = state_q;
        blk_d        = blk_q;
        fail_d       = fail_q;
        fail_block_d = fail_block_q;
        fail_addr_d  = fail_addr_q;
        checkbits_d  = checkbits_q;
        ag_load      = 1'b0;
        ag_load_val  = '0;
        ag_step      = 1'b0;
`ifdef STORAGE_BIST_CONTINUE_EN
        blk_err_d    = blk_err_q;
        err_count_d  = err_count_q;
        fail_mask_d  = fail_mask_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_M0_W;
                    blk_d        = 3'd0;
                    fail_d       = 1'b0;
                    fail_block_d = 3'd0;
                    fail_addr_d  = '0;
                    checkbits_d  = {CODE_STARTED, code(3'd0)};
                    ag_load      = 1'b1;
`ifdef STORAGE_BIST_CONTINUE_EN
                    blk_err_d    = 1'b0;
                    err_count_d  = 16'd0;
                    fail_mask_d  = '0;
`endif
                end
            end
            ST_M0_W: begin
                if (ag_last) begin
                    state_d = ST_M1_RD;
                    ag_load = 1'b1;
                end else begin
                    ag_step = 1'b1;
                end
            end
            ST_M1_RD: state_d = ST_M1_CW;
            ST_M1_CW: begin
                if (ag_last) begin
                    state_d     = ST_M2_RD;
                    ag_load     = 1'b1;
                    ag_load_val = '1;
                end else begin
                    state_d = ST_M1_RD;
                    ag_step = 1'b1;
                end
            end
            ST_M2_RD: state_d = ST_M2_CW;
            ST_M2_CW: begin
                if (ag_last) begin
                    state_d = ST_M3_RD;
                    ag_load = 1'b1;
                end else begin
                    state_d = ST_M2_RD;
                    ag_step = 1'b1;
                end
            end
            ST_M3_RD: state_d = ST_M3_CMP;
            ST_M3_CMP: begin
                if (ag_last) begin
                    state_d     = ST_BLK_END;
                    checkbits_d = {CODE_DONE, code(blk_q) | 8'h01};
`ifdef STORAGE_BIST_CONTINUE_EN
                    if (blk_err_q || miscompare) begin
                        checkbits_d = {CODE_DONE, code(blk_q)};
                    end
`endif
                end else begin
                    state_d = ST_M3_RD;
                    ag_step = 1'b1;
                end
            end
            ST_BLK_END: begin
                if (blk_q == BLK_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d     = ST_M0_W;
                    blk_d       = blk_q + 3'd1;
                    checkbits_d = {CODE_STARTED, code(blk_q + 3'd1)};
                    ag_load     = 1'b1;
`ifdef STORAGE_BIST_CONTINUE_EN
                    blk_err_d   = 1'b0;
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (miscompare) begin
            if (!fail_q) begin
                fail_block_d = blk_q;
                fail_addr_d  = ag_addr;
            end
            fail_d = 1'b1;
`ifdef STORAGE_BIST_CONTINUE_EN
            blk_err_d   = 1'b1;
            fail_mask_d = fail_mask_q | blk_onehot;
            if (err_count_q != 16'hFFFF) begin
                err_count_d = err_count_q + 16'd1;
            end
`else
            checkbits_d = {CODE_DONE, code(blk_q)};
            state_d     = ST_DONE;
            ag_load     = 1'b0;
            ag_step     = 1'b0;
`endif
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            blk_q        <= 3'd0;
            fail_q       <= 1'b0;
            fail_block_q <= 3'd0;
            fail_addr_q  <= '0;
            checkbits_q  <= 16'h0000;
`ifdef STORAGE_BIST_CONTINUE_EN
            blk_err_q    <= 1'b0;
            err_count_q  <= 16'd0;
            fail_mask_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            blk_q        <= blk_d;
            fail_q       <= fail_d;
            fail_block_q <= fail_block_d;
            fail_addr_q  <= fail_addr_d;
            checkbits_q  <= checkbits_d;
`ifdef STORAGE_BIST_CONTINUE_EN
            blk_err_q    <= blk_err_d;
            err_count_q  <= err_count_d;
            fail_mask_q  <= fail_mask_d;
`endif
        end
    end

    // M3_CMP only consumes read data, so it issues no memory cycle.
    assign mem_access = (state_q == ST_M0_W)  || (state_q == ST_M1_RD) || (state_q == ST_M1_CW) ||
                        (state_q == ST_M2_RD) || (state_q == ST_M2_CW) || (state_q == ST_M3_RD);

    for (genvar gi = 0; gi < NBLOCKS; gi++) begin : g_csb
        assign mem_csb[gi] = ~(mem_access && (blk_q == 3'(gi)));
    end

    assign mem_web    = ~((state_q == ST_M0_W) || (state_q == ST_M1_CW) || (state_q == ST_M2_CW));
    assign mem_wmask  = '1;
    assign mem_addr   = ag_addr;
    assign mem_din    = (state_q == ST_M1_CW) ? P1 : P0;

    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign fail       = fail_q;
    assign fail_block = fail_block_q;
    assign fail_addr  = fail_addr_q;
    assign checkbits  = checkbits_q;
`ifdef STORAGE_BIST_CONTINUE_EN
    assign err_count  = err_count_q;
    assign fail_mask  = fail_mask_q;
`endif

endmodule

// File: tb/tb_storage_bist.sv
// Scoreboard bench for storage_bist (NBLOCKS=2, AW=4) with an OpenRAM-like memory and fault injection.
module tb_storage_bist;

    localparam int NB = 2;
    localparam int AW = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic        f;
        logic [2:0]  blk;
        logic [3:0]  addr;
        logic [15:0] errs;
        logic [1:0]  mask;
    } done_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              busy, done, fail;
    logic [2:0]        fail_block;
    logic [AW-1:0]     fail_addr;
    logic [15:0]       checkbits;
    logic [NB-1:0]     mem_csb;
    logic              mem_web;
    logic [DW/8-1:0]   mem_wmask;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_din;
    logic [NB*DW-1:0]  mem_dout;
`ifdef STORAGE_BIST_CONTINUE_EN
    logic [15:0]       err_count;
    logic [NB-1:0]     fail_mask;
`endif

    always #5 clk = ~clk;

    storage_bist #(.NBLOCKS(NB), .AW(AW), .DW(DW), .BG(32'h5555_AAAA)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_block (fail_block),
        .fail_addr  (fail_addr),
        .checkbits  (checkbits),
        .mem_csb    (mem_csb),
        .mem_web    (mem_web),
        .mem_wmask  (mem_wmask),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
`ifdef STORAGE_BIST_CONTINUE_EN
        ,
        .err_count  (err_count),
        .fail_mask  (fail_mask)
`endif
    );

    // Memory model: 1-cycle registered read, optional stuck-at-1 bit 3 or write coupling fault.
    logic [DW-1:0] mem [NB][16];
    logic [DW-1:0] dout_r [NB];
    int fault_mode = 0;
    int fault_blk  = 0;
    int fault_addr = 0;
    assign mem_dout = {dout_r[1], dout_r[0]};

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (!mem_csb[b]) begin
                if (!mem_web) begin
                    mem[b][mem_addr] <= mem_din;
                    if (fault_mode == 2 && b == 0 && mem_addr == 4'd2) mem[b][3] <= ~mem[b][3];
                end else if (fault_mode == 1 && b == fault_blk && int'(mem_addr) == fault_addr) begin
                    dout_r[b] <= mem[b][mem_addr] | 32'h0000_0008;
                end else begin
                    dout_r[b] <= mem[b][mem_addr];
                end
            end
        end
    end

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_cb[$];
    done_t       exp_done[$];
    int wr_cnt = 0, rd_cnt = 0, multi_sel = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected checkbits on every change and expected results on each done pulse.
    initial begin
        logic [15:0] cb_prev;
        logic [15:0] e;
        done_t d;
        cb_prev = 16'h0000;
        forever begin
            @(negedge clk);
            if (checkbits !== cb_prev) begin
                if (exp_cb.size() == 0) begin
                    chk("unexpected_checkbits", {16'h0, checkbits}, {16'h0, cb_prev});
                end else begin
                    e = exp_cb.pop_front();
                    chk("checkbits", {16'h0, checkbits}, {16'h0, e});
                    $display("checkbits %h (expected %h)", checkbits, e);
                end
                cb_prev = checkbits;
            end
            if (done === 1'b1) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    d = exp_done.pop_front();
                    chk("done_fail", {31'h0, fail}, {31'h0, d.f});
                    chk("done_busy", {31'h0, busy}, 32'd0);
                    if (d.f) begin
                        chk("fail_block", {29'h0, fail_block}, {29'h0, d.blk});
                        chk("fail_addr", {28'h0, fail_addr}, {28'h0, d.addr});
                    end
`ifdef STORAGE_BIST_CONTINUE_EN
                    chk("err_count", {16'h0, err_count}, {16'h0, d.errs});
                    chk("fail_mask", {30'h0, fail_mask}, {30'h0, d.mask});
`endif
                    $display("done fail=%0d blk=%0d addr=%0d", fail, fail_block, fail_addr);
                end
            end
            if (mem_web === 1'b0) wr_cnt++;
            if (mem_web === 1'b1 && mem_csb !== 2'b11) rd_cnt++;
            if (mem_csb === 2'b00) multi_sel++;
        end
    end

    task automatic push4(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
        exp_cb.push_back(a);
        exp_cb.push_back(b);
        exp_cb.push_back(c);
        exp_cb.push_back(d);
    endtask

    task automatic do_run(input bit extra_pulses, output int cyc);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 2000) begin
            start = extra_pulses && (cyc == 10 || cyc == 120 || cyc == 200);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (done !== 1'b1) chk("run_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int cyc;
        done_t d;
        for (int b = 0; b < NB; b++) begin
            dout_r[b] = '0;
            for (int a = 0; a < 16; a++) mem[b][a] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_fail", {31'h0, fail}, 32'd0);
        chk("rst_fail_block", {29'h0, fail_block}, 32'd0);
        chk("rst_fail_addr", {28'h0, fail_addr}, 32'd0);
        chk("rst_checkbits", {16'h0, checkbits}, 32'd0);
        chk("rst_csb", {30'h0, mem_csb}, 32'd3);
        chk("rst_web", {31'h0, mem_web}, 32'd1);

        // Fault-free run with stray start pulses while busy.
        push4(16'hA040, 16'hAB41, 16'hA020, 16'hAB21);
        d = '0; exp_done.push_back(d);
        wr_cnt = 0; rd_cnt = 0; multi_sel = 0;
        do_run(1'b1, cyc);
        chk("run_cycles", cyc, 227);
        chk("write_cycles", wr_cnt, 96);
        chk("read_cycles", rd_cnt, 96);
        chk("multi_select", multi_sel, 0);

`ifdef STORAGE_BIST_CONTINUE_EN
        // Stuck-at-1 bit 3 in block 0 address 7: only the M2 read of P1 miscompares.
        fault_mode = 1; fault_blk = 0; fault_addr = 7;
        push4(16'hA040, 16'hAB40, 16'hA020, 16'hAB21);
        d = '0; d.f = 1'b1; d.blk = 3'd0; d.addr = 4'd7; d.errs = 16'd1; d.mask = 2'b01;
        exp_done.push_back(d);
        do_run(1'b0, cyc);
        chk("cont_run_cycles", cyc, 227);
`else
        // Stuck-at-1 bit 3 in block 1 address 5: detected in M2 of block 1.
        fault_mode = 1; fault_blk = 1; fault_addr = 5;
        push4(16'hA040, 16'hAB41, 16'hA020, 16'hAB20);
        d = '0; d.f = 1'b1; d.blk = 3'd1; d.addr = 4'd5;
        exp_done.push_back(d);
        do_run(1'b0, cyc);
`endif

        // Coupling fault: writing block 0 address 2 flips address 3.
        fault_mode = 2;
`ifdef STORAGE_BIST_CONTINUE_EN
        push4(16'hA040, 16'hAB40, 16'hA020, 16'hAB21);
        d = '0; d.f = 1'b1; d.blk = 3'd0; d.addr = 4'd3; d.errs = 16'd2; d.mask = 2'b01;
`else
        exp_cb.push_back(16'hA040);
        exp_cb.push_back(16'hAB40);
        d = '0; d.f = 1'b1; d.blk = 3'd0; d.addr = 4'd3;
`endif
        exp_done.push_back(d);
        do_run(1'b0, cyc);

        // Reset during M2 of block 0 aborts the run immediately.
        fault_mode = 0;
        exp_cb.push_back(16'hA040);
        exp_cb.push_back(16'h0000);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (54) @(negedge clk);
        chk("pre_reset_busy", {31'h0, busy}, 32'd1);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("abort_busy", {31'h0, busy}, 32'd0);
        chk("abort_csb", {30'h0, mem_csb}, 32'd3);
        chk("abort_checkbits", {16'h0, checkbits}, 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_idle_csb", {30'h0, mem_csb}, 32'd3);
        chk("abort_idle_web", {31'h0, mem_web}, 32'd1);

        // Clean rerun after the abort.
        push4(16'hA040, 16'hAB41, 16'hA020, 16'hAB21);
        d = '0; exp_done.push_back(d);
        do_run(1'b0, cyc);
        chk("rerun_cycles", cyc, 227);

        chk("cb_queue_empty", exp_cb.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
